// File: rtl/candidate_sorter.sv
// candidate_sorter: sums per-sample match scores over the alpha sweep of each
// (theta, phi) pair, keeps the best k pairs of the current stage in a sorted
// working list, and publishes that list to double-buffered output registers
// at stage end with a one-cycle sorted_rdy pulse.
module candidate_sorter #(
    parameter int MAX_CAND = 10,
    parameter int ANG_W    = 12,
    parameter int SCORE_W  = 16,
    parameter int ACC_W    = SCORE_W + 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_stageTrigger,
    input  logic                          i_scoreValid,
    input  logic [SCORE_W-1:0]            i_score,
    input  logic [ANG_W-1:0]              i_theta,
    input  logic [ANG_W-1:0]              i_phi,
    input  logic                          i_lastIn,
    input  logic [8:0]                    i_scoreAlphaNum,
    input  logic [3:0]                    i_compareNum,
    output logic [MAX_CAND*2*ANG_W-1:0]   o_candidateAngleBuffer,
    output logic [3:0]                    o_candCount,
    output logic [ACC_W-1:0]              o_bestScore,
    output logic                          o_sortedRdy
);

    localparam logic [3:0] MAX_K = 4'(MAX_CAND);

    typedef enum logic [1:0] {
        COLLECT,
        PUBLISH,
        DONE
    } sorterState_t;

    sorterState_t       r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [8:0]         r_cnt;
    logic               r_pendValid;
    logic [ACC_W-1:0]   r_pendSum;
    logic [ANG_W-1:0]   r_pendTheta;
    logic [ANG_W-1:0]   r_pendPhi;
    logic               r_pendLast;

    logic               r_listValid [MAX_CAND];
    logic [ACC_W-1:0]   r_listSum   [MAX_CAND];
    logic [ANG_W-1:0]   r_listTheta [MAX_CAND];
    logic [ANG_W-1:0]   r_listPhi   [MAX_CAND];

    logic [8:0]         w_numEff;
    logic [3:0]         w_kEff;
    logic               w_groupDone;
    logic               w_doInsert;
    logic [ACC_W-1:0]   w_groupSum;
    logic               w_hit;
    logic [3:0]         w_idx;
    logic [3:0]         w_nextCount;

    logic               w_nValid [MAX_CAND];
    logic [ACC_W-1:0]   w_nSum   [MAX_CAND];
    logic [ANG_W-1:0]   w_nTheta [MAX_CAND];
    logic [ANG_W-1:0]   w_nPhi   [MAX_CAND];

    assign w_numEff    = (i_scoreAlphaNum == 9'd0) ? 9'd1 : i_scoreAlphaNum;
    assign w_kEff      = (i_compareNum == 4'd0)  ? 4'd1 :
                         (i_compareNum > MAX_K)  ? MAX_K : i_compareNum;
    assign w_groupDone = (r_state == COLLECT) && i_scoreValid && (r_cnt == w_numEff - 9'd1);
    assign w_doInsert  = (r_state == COLLECT) && r_pendValid;
    assign w_groupSum  = r_acc + ACC_W'(i_score);

    // Single-cycle compare-and-shift: find the first slot the pending sum beats
    // (strictly, so ties keep the older entry ahead) and build the next list.
    always_comb begin
        w_hit       = 1'b0;
        w_idx       = '0;
        w_nextCount = '0;
        for (int i = MAX_CAND - 1; i >= 0; i--) begin
            if ((4'(i) < w_kEff) && (!r_listValid[i] || (r_pendSum > r_listSum[i]))) begin
                w_hit = 1'b1;
                w_idx = 4'(i);
            end
        end
        for (int i = 0; i < MAX_CAND; i++) begin
            w_nValid[i] = r_listValid[i];
            w_nSum[i]   = r_listSum[i];
            w_nTheta[i] = r_listTheta[i];
            w_nPhi[i]   = r_listPhi[i];
        end
        if (w_doInsert && w_hit) begin
            for (int i = 1; i < MAX_CAND; i++) begin
                if (4'(i) > w_idx) begin
                    w_nValid[i] = r_listValid[i-1];
                    w_nSum[i]   = r_listSum[i-1];
                    w_nTheta[i] = r_listTheta[i-1];
                    w_nPhi[i]   = r_listPhi[i-1];
                end
            end
            for (int i = 0; i < MAX_CAND; i++) begin
                if (4'(i) == w_idx) begin
                    w_nValid[i] = 1'b1;
                    w_nSum[i]   = r_pendSum;
                    w_nTheta[i] = r_pendTheta;
                    w_nPhi[i]   = r_pendPhi;
                end
            end
        end
        for (int i = 0; i < MAX_CAND; i++) begin
            if (4'(i) >= w_kEff) begin
                w_nValid[i] = 1'b0;
            end
            w_nextCount = w_nextCount + 4'(w_nValid[i]);
        end
    end

    // Stage FSM plus accumulator, pending-insert stage, working list and
    // published output registers; stage_trigger clears everything but outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= COLLECT;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pendValid <= 1'b0;
            r_pendSum   <= '0;
            r_pendTheta <= '0;
            r_pendPhi   <= '0;
            r_pendLast  <= 1'b0;
            for (int i = 0; i < MAX_CAND; i++) begin
                r_listValid[i] <= 1'b0;
                r_listSum[i]   <= '0;
                r_listTheta[i] <= '0;
                r_listPhi[i]   <= '0;
            end
            o_candidateAngleBuffer <= '0;
            o_candCount            <= '0;
            o_bestScore            <= '0;
            o_sortedRdy            <= 1'b0;
        end else begin
            o_sortedRdy <= 1'b0;
            if (i_stageTrigger) begin
                r_state     <= COLLECT;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_pendValid <= 1'b0;
                for (int i = 0; i < MAX_CAND; i++) begin
                    r_listValid[i] <= 1'b0;
                    r_listSum[i]   <= '0;
                end
            end else begin
                case (r_state)
                    COLLECT: begin
                        r_pendValid <= w_groupDone;
                        if (w_groupDone) begin
                            r_pendSum   <= w_groupSum;
                            r_pendTheta <= i_theta;
                            r_pendPhi   <= i_phi;
                            r_pendLast  <= i_lastIn;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                        end else if (i_scoreValid) begin
                            r_acc <= w_groupSum;
                            r_cnt <= r_cnt + 9'd1;
                        end
                        if (w_doInsert) begin
                            for (int i = 0; i < MAX_CAND; i++) begin
                                r_listValid[i] <= w_nValid[i];
                                r_listSum[i]   <= w_nSum[i];
                                r_listTheta[i] <= w_nTheta[i];
                                r_listPhi[i]   <= w_nPhi[i];
                            end
                        end
                        if (w_doInsert && r_pendLast) begin
                            r_state     <= PUBLISH;
                            o_sortedRdy <= 1'b1;
                            o_candCount <= w_nextCount;
                            o_bestScore <= w_nValid[0] ? w_nSum[0] : '0;
                            for (int i = 0; i < MAX_CAND; i++) begin
                                o_candidateAngleBuffer[(i+1)*2*ANG_W-1 -: 2*ANG_W] <=
                                    w_nValid[i] ? {w_nTheta[i], w_nPhi[i]} : '0;
                            end
                        end
                    end
                    PUBLISH: begin
                        r_pendValid <= 1'b0;
                        r_state     <= DONE;
                    end
                    DONE: begin
                        r_pendValid <= 1'b0;
                    end
                    default: begin
                        r_state <= COLLECT;
                    end
                endcase
            end
        end
    end

endmodule
